// File: rtl/stream_loop_harness_if.sv
// Per-channel valid/ready/data tap bundle of the loopback harness.
// The harness drives every signal of a tap; observers take the slave view.
interface stream_loop_harness_if #(
  parameter int NCH = 2,
  parameter int DW  = 32
);
  logic [NCH-1:0]    valid;
  logic [NCH-1:0]    ready;
  logic [NCH*DW-1:0] data;

  modport master (output valid, output ready, output data);
  modport slave  (input valid, input ready, input data);
endinterface

// File: rtl/stream_loop_harness.sv
// N-channel loopback fixture: sequence generator -> DEPTH-entry FIFO -> self-checking
// consumer per channel, with programmable throttling and beat/error counters.
module stream_loop_harness #(
  parameter int DW        = 32,
  parameter int NCH       = 2,
  parameter int DEPTH     = 4,
  parameter int DELAY_GEN = 0,
  parameter int DELAY_CHK = 0,
  parameter int CNTW      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  stream_loop_harness_if.master gen_down,
  stream_loop_harness_if.master chk_up,
  output logic [NCH*CNTW-1:0]   beat_cnt,
  output logic [NCH*16-1:0]     err_cnt,
  output logic [NCH-1:0]        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (DELAY_GEN > 1) ? $clog2(DELAY_GEN + 1) : 1;
  localparam int HW = (DELAY_CHK > 1) ? $clog2(DELAY_CHK + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'((DELAY_GEN > 0) ? DELAY_GEN - 1 : 0);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(DELAY_CHK);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {
    GEN_IDLE  = 2'd0,
    GEN_DRIVE = 2'd1,
    GEN_GAP   = 2'd2
  } gen_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    gen_state_e    state_r;
    gen_state_e    state_nxt_s;
    logic [DW-1:0] gen_val_r;
    logic [GW-1:0] gap_cnt_r;
    logic          gen_valid_s;
    logic [DW-1:0] gen_data_s;
    logic          gen_xfer_s;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          empty_s;
    logic          fifo_ready_s;
    logic          pop_s;
    logic [DW-1:0] head_s;

    logic [HW-1:0]   hold_r;
    logic            chk_ready_s;
    logic [DW-1:0]   exp_r;
    logic [CNTW-1:0] beat_r;
    logic [15:0]     err_cnt_r;
    logic            err_r;

    // Generator state, sequence value and gap timer
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r   <= GEN_IDLE;
        gen_val_r <= DW'(c);
        gap_cnt_r <= '0;
      end else begin
        state_r <= state_nxt_s;
        if (gen_xfer_s) begin
          gen_val_r <= gen_val_r + DW'(1);
        end
        // Timer is zero on GAP entry because it is cleared in every other state.
        if (state_r == GEN_GAP) begin
          gap_cnt_r <= gap_cnt_r + GW'(1);
        end else begin
          gap_cnt_r <= '0;
        end
      end
    end

    // Generator next state
    always_comb begin
      state_nxt_s = state_r;
      case (state_r)
        GEN_IDLE: begin
          if (en) state_nxt_s = GEN_DRIVE;
          else    state_nxt_s = GEN_IDLE;
        end
        GEN_DRIVE: begin
          if (!gen_xfer_s)        state_nxt_s = GEN_DRIVE;
          else if (DELAY_GEN > 0) state_nxt_s = GEN_GAP;
          else if (en)            state_nxt_s = GEN_DRIVE;
          else                    state_nxt_s = GEN_IDLE;
        end
        GEN_GAP: begin
          if (gap_cnt_r != GAP_LAST) state_nxt_s = GEN_GAP;
          else if (en)               state_nxt_s = GEN_DRIVE;
          else                       state_nxt_s = GEN_IDLE;
        end
        default: state_nxt_s = GEN_IDLE;
      endcase
    end

    // Generator outputs: data is only presented while valid
    always_comb begin
      gen_valid_s = 1'b0;
      gen_data_s  = '0;
      case (state_r)
        GEN_DRIVE: begin
          gen_valid_s = 1'b1;
          gen_data_s  = gen_val_r;
        end
        default: begin
          gen_valid_s = 1'b0;
          gen_data_s  = '0;
        end
      endcase
    end

    // Ready looks only at occupancy, so a pop never frees a slot in the same cycle.
    assign full_s       = (count_r == FULL_CNT);
    assign empty_s      = (count_r == CW'(0));
    assign fifo_ready_s = !full_s && !rst;
    assign gen_xfer_s   = gen_valid_s && fifo_ready_s;
    assign pop_s        = !empty_s && chk_ready_s;
    assign head_s       = mem_r[rd_ptr_r];

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_r[i] <= '0;
        end
      end else begin
        if (gen_xfer_s) begin
          mem_r[wr_ptr_r] <= gen_data_s;
          wr_ptr_r        <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({gen_xfer_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end

    assign chk_ready_s = !rst && (hold_r == HW'(0));

    // Checker: compare, resync expected to received+1, count beats and errors
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_r    <= '0;
        exp_r     <= DW'(c);
        beat_r    <= '0;
        err_cnt_r <= '0;
        err_r     <= 1'b0;
      end else if (pop_s) begin
        hold_r <= HOLD_LOAD;
        exp_r  <= head_s + DW'(1);
        beat_r <= beat_r + CNTW'(1);
        if (head_s != exp_r) begin
          err_r     <= 1'b1;
          err_cnt_r <= sat_inc16(err_cnt_r);
        end
      end else if (hold_r != HW'(0)) begin
        hold_r <= hold_r - HW'(1);
      end
    end

    assign gen_down.valid[c]            = gen_valid_s;
    assign gen_down.data[c*DW +: DW]    = gen_data_s;
    assign gen_down.ready[c]            = fifo_ready_s;
    assign chk_up.valid[c]              = !empty_s;
    assign chk_up.data[c*DW +: DW]      = head_s;
    assign chk_up.ready[c]              = chk_ready_s;
    assign beat_cnt[c*CNTW +: CNTW]     = beat_r;
    assign err_cnt[c*16 +: 16]          = err_cnt_r;
    assign err[c]                       = err_r;
  end

endmodule

// File: tb/tb_stream_loop_harness.sv
// Directed bench: three harness instances (default, checker-throttled, 8-bit/4-bit-counter)
// driven from one linear sequence on a shared clock.
module tb_stream_loop_harness;
  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;

  always #5 clk = ~clk;

  stream_loop_harness_if #(.NCH(2), .DW(32)) gen0_if ();
  stream_loop_harness_if #(.NCH(2), .DW(32)) chk0_if ();
  stream_loop_harness_if #(.NCH(2), .DW(32)) gen1_if ();
  stream_loop_harness_if #(.NCH(2), .DW(32)) chk1_if ();
  stream_loop_harness_if #(.NCH(1), .DW(8))  gen2_if ();
  stream_loop_harness_if #(.NCH(1), .DW(8))  chk2_if ();

  logic [63:0] beat0;
  logic [31:0] ecnt0;
  logic [1:0]  err0;
  logic [63:0] beat1;
  logic [31:0] ecnt1;
  logic [1:0]  err1;
  logic [3:0]  beat2;
  logic [15:0] ecnt2;
  logic [0:0]  err2;

  stream_loop_harness #(.DW(32), .NCH(2), .DEPTH(4), .DELAY_GEN(0), .DELAY_CHK(0), .CNTW(32)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .gen_down(gen0_if), .chk_up(chk0_if),
    .beat_cnt(beat0), .err_cnt(ecnt0), .err(err0));

  stream_loop_harness #(.DW(32), .NCH(2), .DEPTH(4), .DELAY_GEN(0), .DELAY_CHK(3), .CNTW(32)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .gen_down(gen1_if), .chk_up(chk1_if),
    .beat_cnt(beat1), .err_cnt(ecnt1), .err(err1));

  stream_loop_harness #(.DW(8), .NCH(1), .DEPTH(4), .DELAY_GEN(0), .DELAY_CHK(0), .CNTW(4)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .gen_down(gen2_if), .chk_up(chk2_if),
    .beat_cnt(beat2), .err_cnt(ecnt2), .err(err2));

  int tests_run = 0;
  int tests_failed = 0;
  int k = 0;
  bit sb0_on = 1'b0, sb0_vld = 1'b0, sb1_on = 1'b0, sb2_on = 1'b0;
  logic [31:0] exp0 [2];
  logic [31:0] exp1 [2];
  logic [7:0]  exp2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle; scoreboards follow every accepted checker-side beat in order.
  task automatic tick();
    @(negedge clk);
    k++;
    for (int c = 0; c < 2; c++) begin
      if (sb0_on && chk0_if.valid[c] && chk0_if.ready[c]) begin
        check($sformatf("d0_ch%0d_data_k%0d", c, k), chk0_if.data[c*32 +: 32], exp0[c]);
        exp0[c]++;
      end
      if (sb1_on && chk1_if.valid[c] && chk1_if.ready[c]) begin
        check($sformatf("d1_ch%0d_data_k%0d", c, k), chk1_if.data[c*32 +: 32], exp1[c]);
        exp1[c]++;
      end
    end
    if (sb0_vld) check($sformatf("d0_valid_steady_k%0d", k), chk0_if.valid, 2'b11);
    if (sb2_on && chk2_if.valid[0] && chk2_if.ready[0]) begin
      check($sformatf("d2_data_k%0d", k), chk2_if.data, exp2);
      exp2++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    ticks(3);
    check("rst_d0_gen_valid", gen0_if.valid, 2'b00);
    check("rst_d0_gen_ready", gen0_if.ready, 2'b00);
    check("rst_d0_gen_data", gen0_if.data, 64'h0);
    check("rst_d0_chk_valid", chk0_if.valid, 2'b00);
    check("rst_d0_chk_ready", chk0_if.ready, 2'b00);
    check("rst_d0_chk_data", chk0_if.data, 64'h0);
    check("rst_d0_beat", beat0, 64'h0);
    check("rst_d0_errcnt", ecnt0, 32'h0);
    check("rst_d0_err", err0, 2'b00);
    check("rst_d1_chk_ready", chk1_if.ready, 2'b00);
    check("rst_d2_beat", beat2, 4'h0);

    // Release everything together; k counts rising edges since release.
    exp0[0] = 32'd0; exp0[1] = 32'd1;
    exp1[0] = 32'd0; exp1[1] = 32'd1;
    exp2 = 8'd0;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    sb0_on = 1'b1; sb1_on = 1'b1; sb2_on = 1'b1;
    k = 0;

    tick();
    check("d0_fill_latency", chk0_if.valid, 2'b00);
    check("d0_ready_after_rst", chk0_if.ready, 2'b11);
    sb0_vld = 1'b1;

    ticks(5);
    check("d1_full_gen_ready", gen1_if.ready, 2'b00);
    check("d1_full_gen_valid", gen1_if.valid, 2'b11);

    ticks(13);
    check("d2_beat_wrap_17", beat2, 4'd1);

    ticks(24);
    check("d1_beat_1per4", beat1, {32'd11, 32'd11});

    tick();
    check("d1_stall_valid", gen1_if.valid, 2'b11);
    check("d1_stall_ready", gen1_if.ready, 2'b00);
    check("d1_stall_data", gen1_if.data, {32'd16, 32'd15});
    en1 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("d1_hold_valid_%0d", i), gen1_if.valid, 2'b11);
      check($sformatf("d1_hold_data_%0d", i), gen1_if.data, {32'd16, 32'd15});
    end

    tick();
    check("d1_idle_after_xfer", gen1_if.valid, 2'b00);
    ticks(4);
    check("d1_idle_no_en", gen1_if.valid, 2'b00);
    en1 = 1'b1;
    tick();
    check("d1_resume_valid", gen1_if.valid, 2'b11);
    check("d1_resume_data", gen1_if.data, {32'd17, 32'd16});

    // Three entries are queued here; reset lands mid-cycle.
    ticks(2);
    check("d1_queued_valid", chk1_if.valid, 2'b11);
    #2 rst1 = 1'b1;
    #1;
    check("d1_async_gen_valid", gen1_if.valid, 2'b00);
    check("d1_async_gen_ready", gen1_if.ready, 2'b00);
    check("d1_async_chk_valid", chk1_if.valid, 2'b00);
    check("d1_async_chk_ready", chk1_if.ready, 2'b00);
    check("d1_async_chk_data", chk1_if.data, 64'h0);
    check("d1_async_beat", beat1, 64'h0);
    tick();
    rst1 = 1'b0;
    exp1[0] = 32'd0; exp1[1] = 32'd1;
    ticks(2);
    check("d1_restart_valid", chk1_if.valid, 2'b11);
    check("d1_restart_data", chk1_if.data, {32'd1, 32'd0});
    check("d1_restart_beat", beat1, 64'h0);
    check("d1_restart_errcnt", ecnt1, 32'h0);

    ticks(42);
    check("d0_beat_100cyc", beat0, {32'd98, 32'd98});
    check("d0_err_clean", err0, 2'b00);
    sb0_on = 1'b0; sb0_vld = 1'b0;

    // One corrupted ch1 beat; the following true beat misses the resynced expectation once.
    force dut0.g_ch[1].head_s = 32'hDEAD;
    tick();
    release dut0.g_ch[1].head_s;
    check("d0_corrupt_err", err0, 2'b10);
    check("d0_corrupt_errcnt", ecnt0, {16'd1, 16'd0});
    ticks(9);
    check("d0_resync_errcnt", ecnt0, {16'd2, 16'd0});
    check("d0_resync_err", err0, 2'b10);
    check("d0_resync_beat", beat0, {32'd108, 32'd108});

    ticks(147);
    check("d2_data_ff", chk2_if.data, 8'hFF);
    tick();
    check("d2_data_wrap_00", chk2_if.data, 8'h00);
    check("d2_beat_256", beat2, 4'd0);
    check("d2_err_clean", err2, 1'b0);
    check("d1_err_clean", err1, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
